// File: rtl/fc_argmax_pkg.sv
// Shared constants for the fc_argmax classification stage: BRAM layout, read
// latency, score width, FSM state encoding and the signed score compare.
package fc_argmax_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int RESULT_BASE = 18400;
  localparam int READ_LAT    = 3;
  localparam int DATA_SIZE   = 8;

  localparam int ADDR_W = 15;
  localparam int IDX_W  = 4;
  localparam int STEP_W = $clog2(READ_LAT + 1);

  // One-hot state encoding, kept as plain constants for legacy tools.
  localparam logic [3:0] S_IDLE = 4'b0001;
  localparam logic [3:0] S_READ = 4'b0010;
  localparam logic [3:0] S_DONE = 4'b0100;
  localparam logic [3:0] S_HOLD = 4'b1000;

  function automatic logic score_gt(input logic [DATA_SIZE-1:0] a,
                                    input logic [DATA_SIZE-1:0] b);
    return $signed(a) > $signed(b);
  endfunction

endpackage

// File: rtl/fc_argmax_if.sv
// Read-only port of the result BRAM as seen by fc_argmax (master) and the
// memory itself (slave).
interface fc_argmax_if;
  import fc_argmax_pkg::*;

  logic                 result_bram_ena;
  logic [ADDR_W-1:0]    result_bram_addra;
  logic [DATA_SIZE-1:0] result_bram_douta;

  modport master (
    output result_bram_ena,
    output result_bram_addra,
    input  result_bram_douta
  );

  modport slave (
    input  result_bram_ena,
    input  result_bram_addra,
    output result_bram_douta
  );

endinterface

// File: rtl/fc_argmax_tracker.sv
// Registered running-best (and optional runner-up) score/index pair.
// Second-best tracking is built only when FC_ARGMAX_TOP2_EN is defined.
module argmax_tracker
  import fc_argmax_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 load,
  input  logic                 update,
  input  logic [DATA_SIZE-1:0] score,
  input  logic [IDX_W-1:0]     idx,
  output logic [DATA_SIZE-1:0] best_score,
  output logic [IDX_W-1:0]     best_idx
`ifdef FC_ARGMAX_TOP2_EN
  ,
  output logic [DATA_SIZE-1:0] second_score,
  output logic [IDX_W-1:0]     second_idx
`endif
);

  logic [DATA_SIZE-1:0] best_score_q, best_score_d;
  logic [IDX_W-1:0]     best_idx_q, best_idx_d;
`ifdef FC_ARGMAX_TOP2_EN
  logic [DATA_SIZE-1:0] second_score_q, second_score_d;
  logic [IDX_W-1:0]     second_idx_q, second_idx_d;
  logic                 second_vld_q, second_vld_d;
`endif

  // Next best/second: strict compare, so equal scores keep the earlier index.
  always_comb begin
    best_score_d = best_score_q;
    best_idx_d   = best_idx_q;
`ifdef FC_ARGMAX_TOP2_EN
    second_score_d = second_score_q;
    second_idx_d   = second_idx_q;
    second_vld_d   = second_vld_q;
`endif
    if (clear) begin
      best_score_d = {DATA_SIZE{1'b0}};
      best_idx_d   = {IDX_W{1'b0}};
`ifdef FC_ARGMAX_TOP2_EN
      second_score_d = {DATA_SIZE{1'b0}};
      second_idx_d   = {IDX_W{1'b0}};
      second_vld_d   = 1'b0;
`endif
    end else if (load) begin
      best_score_d = score;
      best_idx_d   = idx;
`ifdef FC_ARGMAX_TOP2_EN
      second_vld_d = 1'b0;
`endif
    end else if (update) begin
      if (score_gt(score, best_score_q)) begin
        best_score_d = score;
        best_idx_d   = idx;
`ifdef FC_ARGMAX_TOP2_EN
        second_score_d = best_score_q;
        second_idx_d   = best_idx_q;
        second_vld_d   = 1'b1;
      end else if (!second_vld_q || score_gt(score, second_score_q)) begin
        second_score_d = score;
        second_idx_d   = idx;
        second_vld_d   = 1'b1;
`endif
      end else begin
        best_score_d = best_score_q;
      end
    end else begin
      best_score_d = best_score_q;
    end
  end

  // Tracker state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_score_q <= {DATA_SIZE{1'b0}};
      best_idx_q   <= {IDX_W{1'b0}};
`ifdef FC_ARGMAX_TOP2_EN
      second_score_q <= {DATA_SIZE{1'b0}};
      second_idx_q   <= {IDX_W{1'b0}};
      second_vld_q   <= 1'b0;
`endif
    end else begin
      best_score_q <= best_score_d;
      best_idx_q   <= best_idx_d;
`ifdef FC_ARGMAX_TOP2_EN
      second_score_q <= second_score_d;
      second_idx_q   <= second_idx_d;
      second_vld_q   <= second_vld_d;
`endif
    end
  end

  assign best_score = best_score_q;
  assign best_idx   = best_idx_q;
`ifdef FC_ARGMAX_TOP2_EN
  assign second_score = second_score_q;
  assign second_idx   = second_idx_q;
`endif

endmodule

// File: rtl/fc_argmax.sv
// Reads the ten fc_2 class scores back from the result BRAM and reports the
// signed argmax. FC_ARGMAX_TOP2_EN additionally reports the runner-up.
module fc_argmax
  import fc_argmax_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 argmax_en,
  fc_argmax_if.master          bram,
  output logic [IDX_W-1:0]     class_id,
  output logic [DATA_SIZE-1:0] class_score,
  output logic                 class_vld,
  output logic                 argmax_finish
`ifdef FC_ARGMAX_TOP2_EN
  ,
  output logic [IDX_W-1:0]     second_id,
  output logic [DATA_SIZE-1:0] second_score
`endif
);

  localparam logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(RESULT_BASE);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_CLASSES - 1);
  localparam logic [STEP_W-1:0] SAMPLE_STEP = STEP_W'(READ_LAT);

  logic [3:0]           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic                 ena_q, ena_d;
  logic [ADDR_W-1:0]    addra_q, addra_d;
  logic [IDX_W-1:0]     class_id_q, class_id_d;
  logic [DATA_SIZE-1:0] class_score_q, class_score_d;
  logic                 class_vld_q, class_vld_d;
  logic                 finish_q, finish_d;
`ifdef FC_ARGMAX_TOP2_EN
  logic [IDX_W-1:0]     second_id_q, second_id_d;
  logic [DATA_SIZE-1:0] second_score_q, second_score_d;
  logic [IDX_W-1:0]     trk_second_idx;
  logic [DATA_SIZE-1:0] trk_second_score;
`endif

  logic                 trk_clear, trk_load, trk_update;
  logic [IDX_W-1:0]     trk_best_idx;
  logic [DATA_SIZE-1:0] trk_best_score;

  argmax_tracker u_tracker (
    .clk          (clk),
    .rst          (rst),
    .clear        (trk_clear),
    .load         (trk_load),
    .update       (trk_update),
    .score        (bram.result_bram_douta),
    .idx          (idx_q),
    .best_score   (trk_best_score),
    .best_idx     (trk_best_idx)
`ifdef FC_ARGMAX_TOP2_EN
    ,
    .second_score (trk_second_score),
    .second_idx   (trk_second_idx)
`endif
  );

  // Run sequencing; argmax_en low in S_READ/S_DONE leaves every register as is.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    step_d        = step_q;
    ena_d         = ena_q;
    addra_d       = addra_q;
    class_id_d    = class_id_q;
    class_score_d = class_score_q;
    class_vld_d   = class_vld_q;
    finish_d      = finish_q;
    trk_clear     = 1'b0;
    trk_load      = 1'b0;
    trk_update    = 1'b0;
`ifdef FC_ARGMAX_TOP2_EN
    second_id_d    = second_id_q;
    second_score_d = second_score_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (argmax_en) begin
          idx_d       = {IDX_W{1'b0}};
          step_d      = {STEP_W{1'b0}};
          class_vld_d = 1'b0;
          trk_clear   = 1'b1;
          state_d     = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (argmax_en) begin
          if (step_q == SAMPLE_STEP) begin
            trk_load   = (idx_q == {IDX_W{1'b0}});
            trk_update = (idx_q != {IDX_W{1'b0}});
            if (idx_q == LAST_IDX) begin
              ena_d   = 1'b0;
              state_d = S_DONE;
            end else begin
              idx_d  = idx_q + IDX_W'(1);
              step_d = {STEP_W{1'b0}};
            end
          end else begin
            if (step_q == {STEP_W{1'b0}}) begin
              ena_d   = 1'b1;
              addra_d = BASE_ADDR + ADDR_W'(idx_q);
            end else begin
              ena_d = ena_q;
            end
            step_d = step_q + STEP_W'(1);
          end
        end else begin
          state_d = S_READ;
        end
      end
      S_DONE: begin
        if (argmax_en) begin
          class_id_d    = trk_best_idx;
          class_score_d = trk_best_score;
          class_vld_d   = 1'b1;
          finish_d      = 1'b1;
`ifdef FC_ARGMAX_TOP2_EN
          second_id_d    = trk_second_idx;
          second_score_d = trk_second_score;
`endif
          state_d       = S_HOLD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_HOLD: begin
        finish_d = 1'b0;
        if (!argmax_en) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        ena_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= {IDX_W{1'b0}};
      step_q        <= {STEP_W{1'b0}};
      ena_q         <= 1'b0;
      addra_q       <= {ADDR_W{1'b0}};
      class_id_q    <= {IDX_W{1'b0}};
      class_score_q <= {DATA_SIZE{1'b0}};
      class_vld_q   <= 1'b0;
      finish_q      <= 1'b0;
`ifdef FC_ARGMAX_TOP2_EN
      second_id_q    <= {IDX_W{1'b0}};
      second_score_q <= {DATA_SIZE{1'b0}};
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      step_q        <= step_d;
      ena_q         <= ena_d;
      addra_q       <= addra_d;
      class_id_q    <= class_id_d;
      class_score_q <= class_score_d;
      class_vld_q   <= class_vld_d;
      finish_q      <= finish_d;
`ifdef FC_ARGMAX_TOP2_EN
      second_id_q    <= second_id_d;
      second_score_q <= second_score_d;
`endif
    end
  end

  assign bram.result_bram_ena   = ena_q;
  assign bram.result_bram_addra = addra_q;
  assign class_id               = class_id_q;
  assign class_score            = class_score_q;
  assign class_vld              = class_vld_q;
  assign argmax_finish          = finish_q;
`ifdef FC_ARGMAX_TOP2_EN
  assign second_id              = second_id_q;
  assign second_score           = second_score_q;
`endif

endmodule

// File: tb/tb_fc_argmax.sv
// Scoreboard bench for fc_argmax: a behavioural BRAM, a reference argmax model,
// and a monitor that checks every finish pulse against queued expectations.
module tb_fc_argmax;
  import fc_argmax_pkg::*;

  typedef struct {
    logic [3:0] id;
    logic [7:0] score;
    logic [3:0] sid;
    logic [7:0] sscore;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       argmax_en;
  logic [3:0] class_id;
  logic [7:0] class_score;
  logic       class_vld;
  logic       argmax_finish;
`ifdef FC_ARGMAX_TOP2_EN
  logic [3:0] second_id;
  logic [7:0] second_score;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  int   n_fin = 0;
  int   cyc   = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  logic [7:0] mem [NUM_CLASSES];
  logic [7:0] rd1 = 8'h00;
  logic [7:0] rd2 = 8'h00;

  fc_argmax_if bus ();

  fc_argmax dut (
    .clk           (clk),
    .rst           (rst),
    .argmax_en     (argmax_en),
    .bram          (bus),
    .class_id      (class_id),
    .class_score   (class_score),
    .class_vld     (class_vld),
    .argmax_finish (argmax_finish)
`ifdef FC_ARGMAX_TOP2_EN
    ,
    .second_id     (second_id),
    .second_score  (second_score)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Two-stage registered BRAM read port.
  function automatic int addr_idx(input logic [14:0] a);
    return int'(a) - RESULT_BASE;
  endfunction

  always @(posedge clk) begin
    if (addr_idx(bus.result_bram_addra) >= 0 && addr_idx(bus.result_bram_addra) < NUM_CLASSES)
      rd1 <= mem[addr_idx(bus.result_bram_addra)];
    else
      rd1 <= 8'h00;
    rd2 <= rd1;
  end
  assign bus.result_bram_douta = rd2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the largest signed value, first index holding it; runner-up is
  // the same search over the remaining indices.
  function automatic exp_t model();
    exp_t e;
    int   mx = -1000;
    int   mx2 = -1000;
    int   b = -1;
    int   s2 = -1;
    for (int i = 0; i < NUM_CLASSES; i++)
      if (int'($signed(mem[i])) > mx) mx = int'($signed(mem[i]));
    for (int i = NUM_CLASSES - 1; i >= 0; i--)
      if (int'($signed(mem[i])) == mx) b = i;
    for (int i = 0; i < NUM_CLASSES; i++)
      if (i != b && int'($signed(mem[i])) > mx2) mx2 = int'($signed(mem[i]));
    for (int i = NUM_CLASSES - 1; i >= 0; i--)
      if (i != b && int'($signed(mem[i])) == mx2) s2 = i;
    e.id     = 4'(b);
    e.score  = 8'(mx);
    e.sid    = 4'(s2);
    e.sscore = 8'(mx2);
    e.cyc    = 0;
    return e;
  endfunction

  // Monitor: every finish pulse must match the oldest outstanding run.
  always @(negedge clk) begin
    if (rst === 1'b0 && argmax_finish === 1'b1) begin
      check("pending_run", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("class_id", 32'(class_id), 32'(mon_e.id));
        check("class_score", 32'(class_score), 32'(mon_e.score));
        check("class_vld", 32'(class_vld), 32'd1);
        check("finish_cycle", 32'(cyc), 32'(mon_e.cyc));
`ifdef FC_ARGMAX_TOP2_EN
        check("second_id", 32'(second_id), 32'(mon_e.sid));
        check("second_score", 32'(second_score), 32'(mon_e.sscore));
`endif
      end
      n_fin++;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ena"}, 32'(bus.result_bram_ena), 32'd0);
    check({tag, "_addra"}, 32'(bus.result_bram_addra), 32'd0);
    check({tag, "_class_id"}, 32'(class_id), 32'd0);
    check({tag, "_class_score"}, 32'(class_score), 32'd0);
    check({tag, "_class_vld"}, 32'(class_vld), 32'd0);
    check({tag, "_finish"}, 32'(argmax_finish), 32'd0);
`ifdef FC_ARGMAX_TOP2_EN
    check({tag, "_second_id"}, 32'(second_id), 32'd0);
    check({tag, "_second_score"}, 32'(second_score), 32'd0);
`endif
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_case(input int pause_len, input bit do_abort);
    exp_t e;
    int   c0;
    int   fin0;
    @(posedge clk);
    #1;
    c0    = cyc;
    e     = model();
    e.cyc = c0 + 42 + pause_len;
    if (!do_abort) exp_q.push_back(e);
    argmax_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("vld_cleared_on_accept", 32'(class_vld), 32'd0);
    if (do_abort) begin
      wait_cycle(c0 + 20);
      rst       = 1'b1;
      argmax_en = 1'b0;
      @(posedge clk);
      #1;
      check_reset_outputs("midrun_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      return;
    end
    if (pause_len > 0) begin
      wait_cycle(c0 + 26);
      argmax_en = 1'b0;
      repeat (pause_len) begin
        @(negedge clk);
        check("addra_frozen", 32'(bus.result_bram_addra), 32'd18406);
        @(posedge clk);
        #1;
      end
      argmax_en = 1'b1;
    end
    fin0 = n_fin;
    for (int i = 0; i < 200 && n_fin == fin0; i++) @(posedge clk);
    check("finish_seen", 32'(n_fin != fin0), 32'd1);
    repeat (6) begin
      @(negedge clk);
      check("hold_vld", 32'(class_vld), 32'd1);
      check("hold_no_finish", 32'(argmax_finish), 32'd0);
    end
    @(posedge clk);
    #1;
    argmax_en = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic load_scores(input int s [NUM_CLASSES]);
    for (int i = 0; i < NUM_CLASSES; i++) mem[i] = 8'(s[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d1 [NUM_CLASSES] = '{5, -3, 17, 2, 17, 0, -128, 9, 1, 16};
    int d2 [NUM_CLASSES] = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128};
    int d3 [NUM_CLASSES] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, 127};
    rst       = 1'b1;
    argmax_en = 1'b0;
    for (int i = 0; i < NUM_CLASSES; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    load_scores(d1);
    run_case(0, 1'b0);
    load_scores(d2);
    run_case(0, 1'b0);
    load_scores(d3);
    run_case(0, 1'b0);
    load_scores(d1);
    run_case(5, 1'b0);
    load_scores(d3);
    run_case(0, 1'b1);
    load_scores(d1);
    run_case(0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NUM_CLASSES; i++) mem[i] = 8'($urandom);
      if (r % 2 == 0) mem[$urandom_range(0, 9)] = mem[$urandom_range(0, 9)];
      run_case((r == 3) ? 5 : 0, 1'b0);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fc_argmax.md
# fc_argmax

Classification stage directly downstream of the second fully connected layer. Once the fc_2 stage has written its ten 8-bit class scores into the result BRAM, this block reads them back one at a time and tracks the running maximum using signed comparison. It then presents the winning class index and its score, along with a one-cycle finish pulse, to the top-level controller and the board outputs.

## Interface
- NUM_CLASSES, 10, number of scores read (indices 0..NUM_CLASSES-1)
- RESULT_BASE, 18400, result BRAM address of class 0; fc_2 writes class k to RESULT_BASE+k
- READ_LAT, 3, cycles from address issue to sampling douta
- DATA_SIZE, 8, score width, two's complement
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- argmax_en  in  1  level enable; run request and freeze control
- result_bram_douta  in  DATA_SIZE  BRAM read data
- result_bram_ena  out  1  BRAM enable (read only; this block never writes)
- result_bram_addra  out  15  BRAM address
- class_id  out  4  index of the maximum score
- class_score  out  DATA_SIZE  maximum score
- class_vld  out  1  class_id/class_score valid
- argmax_finish  out  1  one-cycle pulse when a run completes

## Operation
- States: S_IDLE, S_READ, S_DONE, S_HOLD. One-hot 4-bit encoding.
- S_IDLE, argmax_en=1: clear idx and step; class_vld<=0; go to S_READ.
- S_READ, step 0: result_bram_ena<=1; addra<=RESULT_BASE+idx.
- S_READ, step READ_LAT: sample douta as signed.
  - idx==0: load best unconditionally.
  - Otherwise: replace best only if score > best (strict). Ties therefore keep the lower index.
  - If idx==NUM_CLASSES-1: ena<=0; go to S_DONE. Otherwise idx++; step<=0.
- S_READ, other steps: step++.
- S_DONE: class_id<=best_idx; class_score<=best; class_vld<=1; argmax_finish<=1; go to S_HOLD.
- S_HOLD: argmax_finish<=0. Stay until argmax_en=0, then go to S_IDLE. Outputs hold their values. A new run needs argmax_en to drop and then rise again.
- argmax_en=0 in S_READ or S_DONE: every register freezes, ena and addra included. The run resumes exactly where it stopped when argmax_en returns to 1.
- Comparison is 8-bit signed: 8'h80 = -128 is the minimum and 8'h7F = 127 is the maximum. No widening is needed.
- Any other state encoding goes to S_IDLE with ena=0.

## Timing
- Reset values: result_bram_ena=0, result_bram_addra=0, class_id=0, class_score=0, class_vld=0, argmax_finish=0, state=S_IDLE.
- rst mid-run: the run is aborted on the next edge and every output returns to its reset value.
- Cycle numbering assumes argmax_en held high, with cycle 0 being the S_IDLE cycle that accepts the enable.
  - Element k: address issued at cycle 1+4k, sampled at cycle 4+4k.
  - Last sample at cycle 40. S_DONE at cycle 41.
  - class_vld and argmax_finish are visible from cycle 42. argmax_finish is high for exactly one cycle.
- class_vld falls on the first cycle of the next run, which is the S_IDLE accept cycle.

## Configuration
- FC_ARGMAX_TOP2_EN defined:
  - Adds output ports second_id (4 bits) and second_score (DATA_SIZE). Both reset to 0 and are updated in S_DONE.
  - On each sample: if score > best, the old best moves to second. Otherwise, if second is empty or score > second, the sample becomes second.
  - Ties between equal values resolve to the lower index.
- FC_ARGMAX_TOP2_EN undefined: the ports and the second-best logic are absent. Primary behaviour and timing are identical in both builds.

## Structure
- Package fc_argmax_pkg holds NUM_CLASSES, RESULT_BASE, READ_LAT, DATA_SIZE and the state encoding localparams. fc_2 and the top level also use RESULT_BASE.
- Sub-module argmax_tracker: registered best (and, when configured, second) value/index pair. It has load, compare-update and clear inputs. The FSM in fc_argmax drives it.

## Test plan
- Scores 0..9 = {5,-3,17,2,17,0,-128,9,1,16} -> class_id=2, class_score=17 (tie with index 4 resolves low). finish pulses at cycle 42. With TOP2: second_id=4, second_score=17.
- All scores 8'h80 -> class_id=0, class_score=-128. With TOP2: second_id=1.
- Scores {-1 except index 9 = 127} -> class_id=9. The signed compare must not select 8'hFF as the largest.
- argmax_en low for 5 cycles during element 6 -> same result as an uninterrupted run, delayed by exactly 5 cycles. addra stays at 18406 while frozen.
- rst asserted at cycle 20 -> outputs are reset next edge. A fresh run started afterwards gives the correct result at its cycle 42.
- argmax_en held high after finish -> no second run, class_vld stays 1. Dropping and re-raising argmax_en clears class_vld on the accept cycle and restarts the run.
